// File: rtl/uart_tx_sched_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_sched_pkg
// Shared types and helpers for the UART TX scheduler.
//   sched_state_t : scheduler FSM state encoding (IDLE=0 .. GAP=4)
//   idx_w()       : bits needed to index n items (minimum 1)
// ----------------------------------------------------------------------------
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter_comb
// Combinational round-robin winner select: rotate the request vector so that
// position ptr becomes bit 0, pick the lowest set bit, rotate the index back.
// Ports:
//   req    [N-1:0]  request vector
//   ptr    [IW-1:0] highest-priority position (must be < N)
//   onehot [N-1:0]  one-hot winner (all zero when no request)
//   idx    [IW-1:0] winner index
// ----------------------------------------------------------------------------
module rr_arbiter_comb
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] NW = (IW+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;
    logic           w_hit;

    always_comb begin
        // Doubling the vector turns the rotation into a plain slice, which
        // keeps the wrap correct for non-power-of-two N.
        w_dbl  = {req, req};
        w_rot  = w_dbl[ptr +: N];
        w_off  = '0;
        w_hit  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_hit && w_rot[i]) begin
                w_hit = 1'b1;
                w_off = IW'(i);
            end
        end
        w_sum = {1'b0, w_off} + {1'b0, ptr};
        if (w_sum >= NW) begin
            w_sum = w_sum - NW;
        end
        idx    = w_sum[IW-1:0];
        onehot = '0;
        if (w_hit) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Grants one requester per frame, latches its byte/parity, pulses
// tx_data_valid, follows tx_busy to frame end, then idles GAP_CYCLES clocks.
//
// Optional feature (macro UART_TX_SCHED_TIMEOUT_EN): if tx_busy does not rise
// within TIMEOUT_CYCLES clocks of the issue, set sticky tx_err and return to
// IDLE. Without the macro tx_err is tied low.
//
// Ports:
//   clk, rst_n      clock (rising) / synchronous active-low reset
//   req_valid       per-requester byte pending
//   req_data        packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_par_en      per-requester parity enable
//   req_ack         one-hot one-cycle accept pulse
//   tx_busy         transmitter busy
//   tx_p_data       latched byte to transmitter
//   tx_data_valid   one-cycle issue pulse
//   tx_par_en       latched parity enable
//   grant_id        index of current/last grant
//   active          high from ISSUE until GAP ends
//   tx_err          sticky busy-rise timeout flag
// ----------------------------------------------------------------------------
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_par_en,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic                       tx_busy,
    output logic [DATA_W-1:0]          tx_p_data,
    output logic                       tx_data_valid,
    output logic                       tx_par_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       tx_err
);

    localparam int unsigned IW       = idx_w(NUM_REQ);
    localparam int unsigned GW       = idx_w(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t         r_state;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        r_grant;
    logic [GW-1:0]        r_gap_cnt;
    logic [DATA_W-1:0]    r_data;
    logic                 r_par;
    logic                 r_dv;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_active;

    logic [NUM_REQ-1:0]   w_onehot;
    logic [IW-1:0]        w_idx;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TW = idx_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]        r_to_cnt;
    logic                 r_err;
`endif

    rr_arbiter_comb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .onehot (w_onehot),
        .idx    (w_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_gap_cnt <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_dv      <= 1'b0;
            r_ack     <= '0;
            r_active  <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_dv  <= 1'b0;
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_data   <= req_data[w_idx*DATA_W +: DATA_W];
                        r_par    <= req_par_en[w_idx];
                        r_grant  <= w_idx;
                        // Pulses are registered here so they are high
                        // during the ISSUE cycle itself.
                        r_dv     <= 1'b1;
                        r_ack    <= w_onehot;
                        r_active <= 1'b1;
                        r_state  <= ST_ISSUE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    r_rr_ptr <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                    r_state  <= ST_WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    r_to_cnt <= r_to_cnt + 1'b1;
`endif
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    // Counter started at ISSUE, so the flag lands exactly
                    // TIMEOUT_CYCLES clocks after the issue cycle.
                    else if (r_to_cnt == TO_LAST) begin
                        r_err    <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (GAP_CYCLES == 0) begin
                            r_active <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_active <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack       = r_ack;
    assign tx_p_data     = r_data;
    assign tx_data_valid = r_dv;
    assign tx_par_en     = r_par;
    assign grant_id      = r_grant;
    assign active        = r_active;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign tx_err        = r_err;
`else
    assign tx_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed bench for uart_tx_sched: a NUM_REQ=4 / GAP=2 instance for the main
// sequences and a NUM_REQ=3 / GAP=0 instance for the pointer wrap.
// ----------------------------------------------------------------------------
module tb_uart_tx_sched;

    logic        clk;
    logic        rst_n;

    logic [3:0]  rv, rpe, ack;
    logic [31:0] rd;
    logic        busy, dv, par, act, err;
    logic [7:0]  pdata;
    logic [1:0]  gid;

    logic [2:0]  rv3, rpe3, ack3;
    logic [23:0] rd3;
    logic        busy3, dv3, par3, act3, err3;
    logic [7:0]  pdata3;
    logic [1:0]  gid3;

    int n_pass = 0;
    int n_chk  = 0;
    int n_wait;

    uart_tx_sched #(
        .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(rd),
        .req_par_en(rpe), .req_ack(ack), .tx_busy(busy), .tx_p_data(pdata),
        .tx_data_valid(dv), .tx_par_en(par), .grant_id(gid), .active(act),
        .tx_err(err)
    );

    uart_tx_sched #(
        .NUM_REQ(3), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3),
        .req_par_en(rpe3), .req_ack(ack3), .tx_busy(busy3), .tx_p_data(pdata3),
        .tx_data_valid(dv3), .tx_par_en(par3), .grant_id(gid3), .active(act3),
        .tx_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called right after an issue was observed: runs the frame with tx_busy
    // high for len clocks, checking no re-issue and stable parity.
    task automatic serve(input int len, input logic exp_par);
        tick();
        chk("issue_one_cycle", {31'd0, dv}, 32'd0);
        chk("ack_one_cycle", {28'd0, ack}, 32'd0);
        busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            chk("no_issue_busy", {31'd0, dv}, 32'd0);
            chk("par_stable", {31'd0, par}, {31'd0, exp_par});
        end
        busy = 1'b0;
    endtask

    task automatic wait_issue(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dv !== 1'b1 && n < max);
        chk("issue_seen", {31'd0, dv}, 32'd1);
    endtask

    initial begin
        logic [7:0] exp_b [4];
        int         order [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; rv = '0; rd = '0; rpe = '0; busy = 1'b0;
        rv3 = '0; rd3 = '0; rpe3 = '0; busy3 = 1'b0;
        tick(); tick();
        chk("rst_dv", {31'd0, dv}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_active", {31'd0, act}, 32'd0);
        chk("rst_gid", {30'd0, gid}, 32'd0);
        chk("rst_pdata", {24'd0, pdata}, 32'd0);
        chk("rst_par", {31'd0, par}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Single request, then two more arriving while the first is busy.
        rst_n = 1'b1; rv = 4'b0001; rd[7:0] = 8'hA5; rpe = 4'b0000;
        tick();
        chk("t1_dv", {31'd0, dv}, 32'd1);
        chk("t1_ack", {28'd0, ack}, 32'd1);
        chk("t1_gid", {30'd0, gid}, 32'd0);
        chk("t1_pdata", {24'd0, pdata}, 32'hA5);
        chk("t1_active", {31'd0, act}, 32'd1);
        rv = 4'b0110; rd[15:8] = 8'h5A; rd[23:16] = 8'hC3; rpe = 4'b0010;
        serve(10, 1'b0);
        tick(); chk("gap1_active", {31'd0, act}, 32'd1);
        tick(); chk("gap2_active", {31'd0, act}, 32'd1);
        tick(); chk("idle_active", {31'd0, act}, 32'd0);
        chk("idle_dv", {31'd0, dv}, 32'd0);
        tick();
        chk("f1_dv", {31'd0, dv}, 32'd1);
        chk("f1_gid", {30'd0, gid}, 32'd1);
        chk("f1_ack", {28'd0, ack}, 32'b0010);
        chk("f1_pdata", {24'd0, pdata}, 32'h5A);
        chk("f1_par", {31'd0, par}, 32'd1);

        rv = 4'b0100;
        serve(4, 1'b1);
        wait_issue(8, n_wait);
        chk("f2_spacing", n_wait, 32'd4);
        chk("f2_gid", {30'd0, gid}, 32'd2);
        chk("f2_ack", {28'd0, ack}, 32'b0100);
        chk("f2_pdata", {24'd0, pdata}, 32'hC3);
        chk("f2_par", {31'd0, par}, 32'd0);

        // Reset in WAIT_DONE aborts the frame.
        rv = 4'b0000;
        tick(); busy = 1'b1;
        tick(); tick();
        chk("f2_par_busy", {31'd0, par}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mrst_dv", {31'd0, dv}, 32'd0);
        chk("mrst_active", {31'd0, act}, 32'd0);
        chk("mrst_gid", {30'd0, gid}, 32'd0);
        chk("mrst_pdata", {24'd0, pdata}, 32'd0);
        chk("mrst_par", {31'd0, par}, 32'd0);
        rst_n = 1'b1; busy = 1'b0; rv = 4'b1010;
        tick();
        chk("mrst_grant_dv", {31'd0, dv}, 32'd1);
        chk("mrst_grant_gid", {30'd0, gid}, 32'd1);
        chk("mrst_grant_ack", {28'd0, ack}, 32'b0010);

        // All four requesting continuously: grant order 0,1,2,3,0.
        rst_n = 1'b0; rv = 4'b0000;
        tick();
        rst_n = 1'b1; rv = 4'b1111; rd = 32'h44332211; rpe = 4'b0000;
        tick();
        chk("rr0_dv", {31'd0, dv}, 32'd1);
        chk("rr0_gid", {30'd0, gid}, 32'd0);
        chk("rr0_pdata", {24'd0, pdata}, 32'h11);
        for (int k = 1; k < 5; k++) begin
            serve(3, 1'b0);
            wait_issue(8, n_wait);
            chk("rr_spacing", n_wait, 32'd4);
            chk("rr_gid", {30'd0, gid}, order[k]);
            chk("rr_pdata", {24'd0, pdata}, {24'd0, exp_b[order[k]]});
        end
        rv = 4'b0000;
        serve(3, 1'b0);
        tick(); tick(); tick(); tick();
        chk("end_active", {31'd0, act}, 32'd0);
        chk("end_dv", {31'd0, dv}, 32'd0);
        chk("end_pdata_hold", {24'd0, pdata}, 32'h11);
        chk("end_gid_hold", {30'd0, gid}, 32'd0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        rv = 4'b0001;
        tick();
        chk("to_dv", {31'd0, dv}, 32'd1);
        rv = 4'b0000;
        for (int i = 0; i < 15; i++) tick();
        chk("to_err_early", {31'd0, err}, 32'd0);
        tick();
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_active", {31'd0, act}, 32'd0);
        rv = 4'b0010;
        tick();
        chk("to_next_dv", {31'd0, dv}, 32'd1);
        chk("to_next_gid", {30'd0, gid}, 32'd1);
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        rv = 4'b0000;
`else
        chk("err_tied", {31'd0, err}, 32'd0);
`endif

        // NUM_REQ=3, GAP=0: pointer wraps from 2 to 0.
        rv3 = 3'b100; rd3[23:16] = 8'hBB;
        tick();
        chk("w_dv", {31'd0, dv3}, 32'd1);
        chk("w_gid", {30'd0, gid3}, 32'd2);
        chk("w_ack", {29'd0, ack3}, 32'b100);
        rv3 = 3'b101; rd3[7:0] = 8'hAA;
        tick(); busy3 = 1'b1;
        tick(); tick();
        busy3 = 1'b0;
        tick();
        chk("w_nodv", {31'd0, dv3}, 32'd0);
        tick();
        chk("w2_dv", {31'd0, dv3}, 32'd1);
        chk("w2_gid", {30'd0, gid3}, 32'd0);
        chk("w2_ack", {29'd0, ack3}, 32'b001);
        chk("w2_pdata", {24'd0, pdata3}, 32'hAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
